// File: rtl/mem_burst_requester_if.sv
// Bundles the command, memory and response signals of the burst requester.
//
// Handshakes: the cmd_* and resp_* ports use strict valid/ready. A beat moves on a
// rising clk edge where valid && ready are both high. A source holds valid and its
// payload steady until that edge, and does not use ready to decide valid. A sink may
// raise or drop ready at any time. The mem_* port has no handshake: mem_en marks a
// single-cycle access.
interface mem_burst_requester_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic [DATA_W-1:0] cmd_wdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_op;
  logic              mem_en;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_valid_out;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_last;
  logic              resp_err;

  logic              busy;

  // Requester side.
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata,
    input  mem_data_out, mem_valid_out, resp_ready,
    output cmd_ready, mem_address, mem_data_in, mem_op, mem_en,
    output resp_valid, resp_rdata, resp_last, resp_err, busy
  );

  // Host and memory side.
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata,
    output mem_data_out, mem_valid_out, resp_ready,
    input  cmd_ready, mem_address, mem_data_in, mem_op, mem_en,
    input  resp_valid, resp_rdata, resp_last, resp_err, busy
  );
endinterface

// File: rtl/mem_burst_requester.sv
// Expands host burst commands into single-cycle accesses on a 16x32 memory. The burst
// address wraps around at the top of the address space.
// A write burst drives len+1 back-to-back writes and returns one completion beat.
// A read burst does issue / wait / respond once per word.
module mem_burst_requester #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_requester_if.master bus,
  output logic [1:0]            o_dbg_state
);

  localparam int WAIT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_op;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [3:0]          r_len;
  logic [3:0]          r_beat;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_last;
  logic                r_err;
  logic [WAIT_W-1:0]   r_wait;

  logic w_issue;
  logic w_cmd_hs;
  logic w_resp_hs;

  assign w_issue   = (r_state == S_ISSUE);
  assign w_cmd_hs  = bus.cmd_valid && bus.cmd_ready;
  assign w_resp_hs = (r_state == S_RESP) && bus.resp_ready;

  // Every output is a decode of registered state. cmd_ready is also gated by rst, so
  // no command can be accepted during reset.
  assign bus.cmd_ready   = (r_state == S_IDLE) && !rst;
  assign bus.mem_en      = w_issue;
  assign bus.mem_op      = w_issue && r_op;
  assign bus.mem_address = r_cur_addr;
  assign bus.mem_data_in = (w_issue && r_op) ? r_wdata : '0;
  assign bus.resp_valid  = (r_state == S_RESP);
  assign bus.resp_rdata  = r_rdata;
  assign bus.resp_last   = r_last;
  assign bus.resp_err    = r_err;
  assign bus.busy        = (r_state != S_IDLE);
  assign o_dbg_state     = r_state;

  // Burst sequencer: latch the command, step through the beats, and hold each
  // response until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_cur_addr <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_wait     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_op       <= bus.cmd_op;
            r_cur_addr <= bus.cmd_addr;
            r_len      <= bus.cmd_len;
            r_wdata    <= bus.cmd_wdata;
            r_beat     <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_op) begin
            if (r_beat != r_len) begin
              r_cur_addr <= r_cur_addr + ADDR_W'(1);
              r_beat     <= r_beat + 4'd1;
            end else begin
              // A write returns a single completion beat with no data.
              r_rdata <= '0;
              r_last  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_RESP;
            end
          end else begin
            r_wait  <= WAIT_W'(RD_LATENCY);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - WAIT_W'(1);
          if (r_wait == WAIT_W'(1)) begin
            // The memory's valid flag is sticky, so err only means the memory has
            // never produced a read.
            r_rdata <= bus.mem_data_out;
            r_err   <= ~bus.mem_valid_out;
            r_last  <= (r_beat == r_len);
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            if (r_last) begin
              r_state <= S_IDLE;
            end else begin
              r_cur_addr <= r_cur_addr + ADDR_W'(1);
              r_beat     <= r_beat + 4'd1;
              r_state    <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_requester.sv
// Bench for mem_burst_requester: a memory model, a table of burst vectors, and
// hand-written backpressure, command-blocking and mid-burst reset sequences.
module tb_mem_burst_requester;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef struct {
    logic        op;
    logic [3:0]  addr;
    logic [3:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic        op;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         hs_count = 0;
  acc_t       mlog[$];
  vec_t       vecs[9];

  mem_burst_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_burst_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model. Read data is registered. valid_out is sticky and trails the first
  // read by one cycle, so the very first read after power-up is flagged as an error.
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] mem_q = 32'h0;
  logic        mem_vq = 1'b0;
  logic        rd_seen = 1'b0;
  assign bus.mem_data_out  = mem_q;
  assign bus.mem_valid_out = mem_vq;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_op) mem[bus.mem_address] <= bus.mem_data_in;
    if (bus.mem_en && !bus.mem_op) begin
      mem_q   <= mem[bus.mem_address];
      rd_seen <= 1'b1;
    end
    mem_vq <= rd_seen;
  end

  // Access log and command-handshake counter.
  always @(negedge clk) if (bus.mem_en) mlog.push_back('{bus.mem_address, bus.mem_op, bus.mem_data_in, cyc});
  always @(posedge clk) if (bus.cmd_valid && bus.cmd_ready) hs_count <= hs_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one command and return at the negedge after it is accepted.
  task automatic send_cmd(input logic op, input logic [3:0] addr, input logic [3:0] len, input logic [31:0] wdata);
    int t = 0;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept_in_time", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for a response beat, check it, and return at the negedge after its
  // handshake (resp_ready must already be high). exp_lat is the issue-to-valid
  // distance in cycles; 0 skips that check.
  task automatic get_beat(input string name, input logic [31:0] exp_rdata, input logic exp_last,
                          input logic exp_err, input int exp_lat);
    int t = 0;
    while (!bus.resp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_in_time"}, (t < 50) ? 32'd1 : 32'd0, 32'd1);
    if (exp_lat > 0 && mlog.size() > 0) check({name, "_latency"}, cyc - mlog[$].cyc, exp_lat);
    check({name, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({name, "_last"}, 32'(bus.resp_last), 32'(exp_last));
    check({name, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    @(negedge clk);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int          nb;
    logic [3:0]  ea;
    mlog.delete();
    send_cmd(v.op, v.addr, v.len, v.wdata);
    nb = v.op ? 1 : int'(v.len) + 1;
    for (int b = 0; b < nb; b++)
      get_beat($sformatf("v%0d_b%0d", idx, b), v.exp_rdata, b == nb - 1, v.exp_err, v.op ? 1 : 2);
    check($sformatf("v%0d_access_count", idx), mlog.size(), int'(v.len) + 1);
    foreach (mlog[i]) begin
      ea = v.addr + 4'(i);
      check($sformatf("v%0d_acc%0d_addr", idx, i), 32'(mlog[i].addr), 32'(ea));
      check($sformatf("v%0d_acc%0d_op", idx, i), 32'(mlog[i].op), 32'(v.op));
      check($sformatf("v%0d_acc%0d_wdata", idx, i), mlog[i].data, v.op ? v.wdata : 32'h0);
    end
  endtask

  initial begin
    int t;
    int n;
    int h0;
    int hs_cyc;

    //               op    addr   len    wdata         exp_rdata     exp_err
    vecs[0] = '{1'b0, 4'd0,  4'd0, 32'h0,        32'h0,        1'b1}; // first read: never valid
    vecs[1] = '{1'b1, 4'd3,  4'd0, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 4'd3,  4'd0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 4'd14, 4'd3, 32'hA5A5A5A5, 32'h0,        1'b0}; // 14,15,0,1
    vecs[4] = '{1'b0, 4'd14, 4'd3, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[5] = '{1'b1, 4'd9,  4'd1, 32'h0BADF00D, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 4'd9,  4'd1, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[7] = '{1'b0, 4'd4,  4'd0, 32'h0,        32'h11111111, 1'b0}; // written before the abort
    vecs[8] = '{1'b0, 4'd5,  4'd0, 32'h0,        32'h0,        1'b0}; // abort stopped before addr 5

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.cmd_wdata  = '0;
    bus.resp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i);

    // Backpressure: stall beat 0 of a two-beat read for five cycles.
    mlog.delete();
    bus.resp_ready = 1'b0;
    send_cmd(1'b0, 4'd9, 4'd1, 32'h0);
    t = 0;
    while (!bus.resp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_b0_in_time", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    check("bp_b0_last", 32'(bus.resp_last), 32'd0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("bp_stall%0d_valid", s), 32'(bus.resp_valid), 32'd1);
      check($sformatf("bp_stall%0d_rdata", s), bus.resp_rdata, 32'h0BADF00D);
      check($sformatf("bp_stall%0d_mem_en", s), 32'(bus.mem_en), 32'd0);
      check($sformatf("bp_stall%0d_accesses", s), mlog.size(), 32'd1);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    get_beat("bp_b1", 32'h0BADF00D, 1'b1, 1'b0, 2);
    check("bp_access_count", mlog.size(), 32'd2);
    if (mlog.size() > 1) check("bp_b1_issue_cycle", mlog[1].cyc, hs_cyc);

    // Command blocking: cmd_valid stays high through a whole read burst.
    mlog.delete();
    h0 = hs_count;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = 4'd14;
    bus.cmd_len   = 4'd1;
    bus.cmd_wdata = 32'h0;
    bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("blk_first_accept", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    bus.cmd_addr = 4'd3;
    bus.cmd_len  = 4'd0;
    get_beat("blk_b0", 32'hA5A5A5A5, 1'b0, 1'b0, 2);
    check("blk_ready_mid_burst", 32'(bus.cmd_ready), 32'd0);
    get_beat("blk_b1", 32'hA5A5A5A5, 1'b1, 1'b0, 2);
    check("blk_ready_after_last", 32'(bus.cmd_ready), 32'd1);
    check("blk_accepts_during_burst", hs_count - h0, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("blk_second_accept", hs_count - h0, 32'd2);
    get_beat("blk_c2", 32'hDEADBEEF, 1'b1, 1'b0, 2);
    repeat (3) @(negedge clk);
    check("blk_total_accepts", hs_count - h0, 32'd2);
    check("blk_access_count", mlog.size(), 32'd3);

    // Reset mid-burst: raise rst during the fifth write of a 16-beat burst.
    mlog.delete();
    send_cmd(1'b1, 4'd0, 4'd15, 32'h11111111);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.mem_en) n++;
      if (n == 5) break;
      @(negedge clk);
    end
    check("abort_reached_5th_issue", n, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_en", 32'(bus.mem_en), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_cmd_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("abort_access_count", mlog.size(), 32'd5);
    run_vector(vecs[7], 7);
    run_vector(vecs[8], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_burst_requester.md
Name: mem_burst_requester

Overview:
- Initiator for the team's 16x32 single-port memory interface: address, data_in, op, en, data_out, valid_out.
- Accepts host commands over a valid/ready port and expands each into 1..16 single-cycle memory accesses at consecutive addresses, wrapping 15 -> 0.
- Write bursts fill consecutive words with one data value. Read bursts return one response beat per word over a valid/ready response port.
- Sits between a host/sequencer and the memory instance.

Parameters:
- ADDR_W, 4, memory address width; burst address wraps modulo 2**ADDR_W.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from the mem_en read cycle to the mem_data_out sample point; legal range >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  1  1 = write, 0 = read (same encoding as mem_op).
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len  in  4  beats minus one (0 -> 1 beat, 15 -> 16 beats).
- cmd_wdata  in  DATA_W  write value applied to every beat of a write burst.
- mem_address  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.
- mem_op  out  1  memory operation.
- mem_en  out  1  memory access strobe.
- mem_data_out  in  DATA_W  memory read data (registered in the memory).
- mem_valid_out  in  1  memory read-valid flag.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  response beat consumed when resp_valid && resp_ready.
- resp_rdata  out  DATA_W  read data; 0 for the write completion beat.
- resp_last  out  1  final beat of the command.
- resp_err  out  1  mem_valid_out was low at the sample point.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered or decoded from registered state.
- While rst=1, on the clock edge:
  - state <= IDLE.
  - mem_en, mem_op, resp_valid, resp_last, resp_err, busy <= 0.
  - mem_address, mem_data_in, resp_rdata <= 0.
  - beat counter <= 0.
  - cmd_ready is forced 0 while rst is high.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch op, addr, len, wdata; clear the beat counter; go to ISSUE next cycle.
- ISSUE:
  - mem_en=1 for exactly this cycle, with mem_op=op, mem_address=cur_addr, mem_data_in=wdata (0 for reads). cmd_ready=0.
  - Write, beat < len: cur_addr <= cur_addr+1 (wrap), beat++, stay in ISSUE. A write burst therefore drives len+1 back-to-back mem_en cycles.
  - Write, beat == len: go to RESP with resp_rdata=0, resp_last=1, resp_err=0.
  - Read: load wait counter with RD_LATENCY, go to WAIT.
- WAIT:
  - mem_en=0. Decrement the wait counter each cycle.
  - On the cycle the counter reaches its final value: capture resp_rdata <= mem_data_out, resp_err <= ~mem_valid_out, resp_last <= (beat == len); go to RESP.
  - With RD_LATENCY=1, data is sampled in the cycle immediately after the ISSUE cycle.
- RESP:
  - resp_valid=1. resp_rdata, resp_last and resp_err stay stable until the handshake.
  - On handshake with resp_last=1: go to IDLE.
  - On handshake with resp_last=0: cur_addr+1 (wrap), beat++, go to ISSUE.
- Read beat timing: ISSUE at cycle T gives resp_valid at T+RD_LATENCY+1. Minimum period is RD_LATENCY+2 cycles per beat with resp_ready held high.
- Exactly one response beat per write command; len+1 beats per read command.
- No new command is accepted until the final response handshake; cmd_ready rises in the cycle after it.
- The memory's valid_out flag is sticky after its first read. resp_err only flags "never read-valid", not per-beat freshness.
- Reset mid-burst: abort immediately. No further mem_en pulses; any pending response is discarded; return to IDLE.
- cmd inputs are ignored outside IDLE.
- resp_ready held low stalls indefinitely in RESP, with mem_en=0 throughout.

Test Plan:
- Single write then read: cmd(op=1, addr=3, len=0, wdata=0xDEADBEEF), then cmd(op=0, addr=3, len=0) -> exactly one mem_en write pulse at address 3; one write response with rdata=0 and last=1; read response rdata=0xDEADBEEF, last=1, err=0, with resp_valid 2 cycles after the read ISSUE.
- Wrapping fill: write addr=14, len=3, wdata=0xA5A5A5A5 -> 4 consecutive mem_en cycles at addresses 14, 15, 0, 1. Then read addr=14, len=3 -> 4 beats of 0xA5A5A5A5; last set only on the 4th beat.
- Backpressure: read len=1 with resp_ready low for 5 cycles on beat 0 -> resp_valid and rdata held constant; no mem_en during the stall; beat 1 issued only after the handshake.
- Error flag: first-ever command after reset is a read of addr=0 (memory valid_out still 0) -> resp_err=1, last=1.
- Reset mid-burst: write len=15, assert rst on the 5th ISSUE cycle -> no mem_en in the following cycle; busy=0 and resp_valid=0. After rst deasserts, cmd_ready=1 and a new command is accepted normally.
- Command blocking: hold cmd_valid high during a read burst -> cmd_ready stays 0 until the cycle after the final response handshake; then exactly one new command is accepted.
